// File: rtl/channel_state_estimator_if.sv
// Sample stream into the channel estimator plus its registered status outputs.
// in_valid alone qualifies a transfer: there is no ready, so every edge with in_valid=1 consumes err_bit.
interface channel_state_estimator_if;
  logic        in_valid;
  logic        err_bit;
  logic        est_state;
  logic [6:0]  win_err_count;
  logic [7:0]  burst_len;
  logic        burst_done;
  logic [15:0] total_errs;

  modport master (
    output in_valid,
    output err_bit,
    input  est_state,
    input  win_err_count,
    input  burst_len,
    input  burst_done,
    input  total_errs
  );

  modport slave (
    input  in_valid,
    input  err_bit,
    output est_state,
    output win_err_count,
    output burst_len,
    output burst_done,
    output total_errs
  );
endinterface

// File: rtl/channel_state_estimator.sv
// Estimates GOOD/BAD channel state from a sliding window of observed bit errors,
// with hysteresis, burst-length measurement and a saturating total error count.
module channel_state_estimator #(
  parameter int WINDOW      = 16,
  parameter int BAD_THRESH  = 4,
  parameter int GOOD_THRESH = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  channel_state_estimator_if.slave  bus
);

  typedef enum logic {
    ST_GOOD = 1'b0,
    ST_BAD  = 1'b1
  } state_e;

  localparam logic [6:0] BAD_T  = 7'(BAD_THRESH);
  localparam logic [6:0] GOOD_T = 7'(GOOD_THRESH);

  state_e              state_q;
  logic [WINDOW-1:0]   win_q;
  logic [WINDOW-1:0]   win_d;
  logic [6:0]          cnt_q;
  logic [6:0]          cnt_d;
  logic [7:0]          burst_cnt_q;
  logic [7:0]          burst_len_q;
  logic                burst_done_q;
  logic [15:0]         total_q;
  logic [15:0]         total_d;
  logic                accept;

  assign accept = bus.in_valid;

  // Bit WINDOW-1 is the oldest sample; it leaves the count as the new bit enters.
  always_comb begin
    win_d   = win_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    if (accept) begin
      for (int i = WINDOW - 1; i > 0; i--) begin
        win_d[i] = win_q[i-1];
      end
      win_d[0] = bus.err_bit;
      cnt_d    = cnt_q + {6'd0, bus.err_bit} - {6'd0, win_q[WINDOW-1]};
      if (bus.err_bit && (total_q != 16'hFFFF)) begin
        total_d = total_q + 16'd1;
      end
    end
  end

  // The FSM decides on the post-update count so the state tracks the sample just taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_GOOD;
      win_q        <= '0;
      cnt_q        <= '0;
      burst_cnt_q  <= '0;
      burst_len_q  <= '0;
      burst_done_q <= 1'b0;
      total_q      <= '0;
    end else begin
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      total_q      <= total_d;
      burst_done_q <= 1'b0;
      if (accept) begin
        case (state_q)
          ST_GOOD: begin
            if (cnt_d >= BAD_T) begin
              state_q     <= ST_BAD;
              burst_cnt_q <= 8'd1;
            end
          end
          ST_BAD: begin
            if (cnt_d <= GOOD_T) begin
              state_q      <= ST_GOOD;
              burst_len_q  <= burst_cnt_q;
              burst_done_q <= 1'b1;
              burst_cnt_q  <= '0;
            end else if (burst_cnt_q != 8'hFF) begin
              burst_cnt_q <= burst_cnt_q + 8'd1;
            end
          end
          default: state_q <= ST_GOOD;
        endcase
      end
    end
  end

  assign bus.est_state     = state_q;
  assign bus.win_err_count = cnt_q;
  assign bus.burst_len     = burst_len_q;
  assign bus.burst_done    = burst_done_q;
  assign bus.total_errs    = total_q;

endmodule

// File: tb/tb_channel_state_estimator.sv
// Directed bench for channel_state_estimator with hand-derived expectations at default parameters.
module tb_channel_state_estimator;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  channel_state_estimator_if bus ();

  channel_state_estimator #(
    .WINDOW      (16),
    .BAD_THRESH  (4),
    .GOOD_THRESH (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic st, input logic [6:0] cnt,
                         input logic done, input logic [7:0] len, input logic [15:0] tot);
    chk({tag, " state"}, {15'd0, bus.est_state}, {15'd0, st});
    chk({tag, " count"}, {9'd0, bus.win_err_count}, {9'd0, cnt});
    chk({tag, " done"},  {15'd0, bus.burst_done}, {15'd0, done});
    chk({tag, " len"},   {8'd0, bus.burst_len}, {8'd0, len});
    chk({tag, " total"}, bus.total_errs, tot);
  endtask

  task automatic send(input logic e);
    bus.in_valid = 1'b1;
    bus.err_bit  = e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.err_bit  = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    bus.err_bit  = 1'b1;
    @(posedge clk);
    #1;
    bus.err_bit  = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.err_bit  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Four errors then zeros: BAD at 4, count drains at 17..20, exit at 19 with a 15-sample burst.
  task automatic run_four_errors(input bit with_idle);
    logic [6:0] ec;
    for (int s = 1; s <= 4; s++) send(1'b1);
    chk_all("s4", 1'b1, 7'd4, 1'b0, 8'd0, 16'd4);
    for (int s = 5; s <= 21; s++) begin
      send(1'b0);
      if (s <= 16) ec = 7'd4;
      else if (s == 17) ec = 7'd3;
      else if (s == 18) ec = 7'd2;
      else if (s == 19) ec = 7'd1;
      else ec = 7'd0;
      chk_all($sformatf("s%0d", s), (s < 19) ? 1'b1 : 1'b0, ec, (s == 19) ? 1'b1 : 1'b0,
              (s >= 19) ? 8'd15 : 8'd0, 16'd4);
      if (with_idle && s == 10) begin
        for (int k = 0; k < 5; k++) begin
          idle_cycle();
          chk_all($sformatf("idle%0d", k), 1'b1, 7'd4, 1'b0, 8'd0, 16'd4);
        end
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.err_bit  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 7'd0, 1'b0, 8'd0, 16'd0);
    reset = 1'b0;

    // Three errors stay below the BAD threshold.
    for (int s = 1; s <= 3; s++) send(1'b1);
    chk_all("three", 1'b0, 7'd3, 1'b0, 8'd0, 16'd3);

    do_reset();
    chk_all("rst2", 1'b0, 7'd0, 1'b0, 8'd0, 16'd0);
    run_four_errors(1'b0);

    do_reset();
    run_four_errors(1'b1);

    // Reset with in_valid high at sample 8 of a burst: everything clears, no done pulse.
    do_reset();
    for (int s = 1; s <= 7; s++) send((s <= 4) ? 1'b1 : 1'b0);
    chk_all("pre_rst", 1'b1, 7'd4, 1'b0, 8'd0, 16'd4);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.err_bit  = 1'b1;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.err_bit  = 1'b0;
    chk_all("mid_rst", 1'b0, 7'd0, 1'b0, 8'd0, 16'd0);
    send(1'b1);
    chk_all("after_rst1", 1'b0, 7'd1, 1'b0, 8'd0, 16'd1);
    for (int s = 2; s <= 17; s++) begin
      send(1'b0);
      chk($sformatf("after_rst s%0d done", s), {15'd0, bus.burst_done}, 16'd0);
    end
    chk_all("after_rst_end", 1'b0, 7'd0, 1'b0, 8'd0, 16'd1);

    // Hysteresis: count sits at 2..3 while BAD, exits only at 1.
    do_reset();
    for (int s = 1; s <= 4; s++) send(1'b1);
    for (int s = 5; s <= 16; s++) send(1'b0);
    chk_all("h16", 1'b1, 7'd4, 1'b0, 8'd0, 16'd4);
    send(1'b0); chk_all("h17", 1'b1, 7'd3, 1'b0, 8'd0, 16'd4);
    send(1'b0); chk_all("h18", 1'b1, 7'd2, 1'b0, 8'd0, 16'd4);
    send(1'b1); chk_all("h19", 1'b1, 7'd2, 1'b0, 8'd0, 16'd5);
    send(1'b1); chk_all("h20", 1'b1, 7'd2, 1'b0, 8'd0, 16'd6);
    send(1'b0); chk_all("h21", 1'b1, 7'd2, 1'b0, 8'd0, 16'd6);
    send(1'b1); chk_all("h22", 1'b1, 7'd3, 1'b0, 8'd0, 16'd7);
    for (int s = 23; s <= 34; s++) send(1'b0);
    chk_all("h34", 1'b1, 7'd3, 1'b0, 8'd0, 16'd7);
    send(1'b0); chk_all("h35", 1'b1, 7'd2, 1'b0, 8'd0, 16'd7);
    send(1'b0); chk_all("h36", 1'b0, 7'd1, 1'b1, 8'd32, 16'd7);
    idle_cycle(); chk_all("h_idle", 1'b0, 7'd1, 1'b0, 8'd32, 16'd7);

    // Long burst: burst counter saturates at 255.
    do_reset();
    for (int s = 1; s <= 300; s++) send(1'b1);
    chk_all("long300", 1'b1, 7'd16, 1'b0, 8'd0, 16'd300);
    for (int s = 301; s <= 314; s++) send(1'b0);
    chk_all("long314", 1'b1, 7'd2, 1'b0, 8'd0, 16'd300);
    send(1'b0);
    chk_all("long315", 1'b0, 7'd1, 1'b1, 8'd255, 16'd300);

    // Total error counter saturates without wrapping.
    do_reset();
    for (int s = 1; s <= 65540; s++) send(1'b1);
    chk_all("sat", 1'b1, 7'd16, 1'b0, 8'd0, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/channel_state_estimator.md
CHANNEL_STATE_ESTIMATOR -- requirements
Module: channel_state_estimator

Interface
REQ-001 Parameter WINDOW, default 16, meaning: length of the sliding error-observation window, in accepted samples.
REQ-002 Parameter BAD_THRESH, default 4, meaning: window error count at or above which the estimate moves GOOD->BAD.
REQ-003 Parameter GOOD_THRESH, default 1, meaning: window error count at or below which the estimate moves BAD->GOOD.
REQ-004 Parameter legality SHALL be 0 <= GOOD_THRESH < BAD_THRESH <= WINDOW and WINDOW <= 64; other values are unsupported.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  err_bit is accepted on a rising edge where in_valid=1.
REQ-008 err_bit  input  1  1 = received bit differed from transmitted bit (channel error observed).
REQ-009 est_state  output  1  0 = GOOD, 1 = BAD; receiver-side estimate of the channel state.
REQ-010 win_err_count  output  7  number of 1s among the last WINDOW accepted err_bit samples.
REQ-011 burst_len  output  8  length in samples of the most recently completed BAD burst.
REQ-012 burst_done  output  1  single-cycle pulse when a BAD burst completes.
REQ-013 total_errs  output  16  count of all accepted err_bit=1 samples since reset.

Function
REQ-014 Window SHALL be a WINDOW-bit shift register; each accepted sample shifts in err_bit and shifts out the oldest bit.
REQ-015 Entries not yet filled since reset SHALL count as 0.
REQ-016 win_err_count SHALL update incrementally: next = current + err_bit - oldest_bit, applied on the accepting edge.
REQ-017 State machine: two states, GOOD and BAD, evaluated only on accepting edges using the updated (next) window count.
REQ-018 GOOD->BAD when the next count >= BAD_THRESH; otherwise remain GOOD.
REQ-019 BAD->GOOD when the next count <= GOOD_THRESH; otherwise remain BAD; counts strictly between the thresholds hold the current state (hysteresis).
REQ-020 Latency: all outputs are registered and reflect a sample on the edge that accepts it; no combinational path exists from inputs to outputs.
REQ-021 Burst counter: the sample causing GOOD->BAD SHALL set it to 1.
REQ-022 Each further accepted sample while BAD, excluding the exit sample, SHALL increment the burst counter, saturating at 255.
REQ-023 On BAD->GOOD, burst_len SHALL load the burst counter and burst_done SHALL be 1 for exactly that cycle.
REQ-024 burst_done SHALL be 0 in all other cycles.
REQ-025 burst_len SHALL hold its value until the next completed burst.
REQ-026 total_errs SHALL increment on each accepted err_bit=1 and saturate at 65535 with no wrap.
REQ-027 When in_valid=0, the window, counts, state, burst counter and burst_len SHALL hold; burst_done SHALL be 0.

Reset
REQ-028 While reset=1 at a rising edge, the block SHALL clear the window, win_err_count, the burst counter, burst_len, burst_done and total_errs to 0 and force est_state to GOOD, overriding in_valid.
REQ-029 Reset asserted mid-burst SHALL NOT produce a burst_done pulse, and the partial burst SHALL be discarded.

Verification (defaults WINDOW=16, BAD_THRESH=4, GOOD_THRESH=1; samples numbered from 1 after reset)
REQ-030 Samples 1-3 with err_bit=1 -> win_err_count=3, est_state=0, total_errs=3.
REQ-031 Samples 1-4 with err_bit=1, then 0s -> est_state=1 after sample 4, win_err_count 4 -> 3 at sample 17, 2 at 18, 1 at 19; est_state=0 after 19; burst_done pulses once at 19 with burst_len=15.
REQ-032 Same stimulus as REQ-031 with in_valid=0 for 5 cycles inserted after sample 10 -> identical per-sample outputs; no state change during idle cycles.
REQ-033 Continuous err_bit=1 for 300 samples, then 0s -> burst_len=255 at exit; total_errs=300.
REQ-034 Reset pulse at sample 8 of the REQ-031 stimulus -> outputs all 0 / GOOD next cycle; no burst_done; the window restarts empty.
REQ-035 Alternating patterns holding the count at 2-3 while BAD -> est_state stays 1 (hysteresis); dropping to 1 -> returns to 0.
